alu_issue_ctrl: RTL

// Execute-stage front end for the clocked ALU. Accepts decoded MIPS ALU instructions on a valid/ready

---
 rtl/alu_issue_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Execute-stage front end for a clocked ALU: decodes MIPS ALU instructions into a/b/aluc,
// waits out the ALU's registered latency and returns a writeback record on a valid/ready handshake.
module alu_issue_ctrl #(
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_shamt,
    input  logic [4:0]  in_rt_idx,
    input  logic [4:0]  in_rd_idx,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic [15:0] in_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_dest,
    output logic        out_wen,
    output logic        out_zero,
    output logic        out_carry,
    output logic        out_negative,
    output logic        out_ovf,
    output logic        out_illegal
);
    typedef enum logic [1:0] {IDLE, EXEC, CAPT, HOLD} state_t;

    state_t      state;
    logic        accept;
    logic [31:0] dec_a, dec_b, imm_sext, imm_zext;
    logic [3:0]  dec_aluc;
    logic [4:0]  dec_dest;
    logic        dec_ovf_class, dec_illegal;
    logic [4:0]  lat_dest;
    logic        lat_ovf_class, lat_illegal;
    logic        cap_ovf;

    assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
    assign accept   = in_valid && in_ready;
    assign imm_sext = {{16{in_imm[15]}}, in_imm};
    assign imm_zext = {16'b0, in_imm};
    // The ALU overflow flag is sticky, so it only counts for the signed add/sub class.
    assign cap_ovf  = lat_ovf_class && alu_overflow;

    always_comb begin
        dec_a         = in_rs_val;
        dec_b         = in_rt_val;
        dec_aluc      = 4'b0000;
        dec_ovf_class = 1'b0;
        dec_illegal   = 1'b0;
        dec_dest      = (in_opcode == 6'h00) ? in_rd_idx : in_rt_idx;
        if (in_opcode == 6'h00) begin
            case (in_funct)
                6'h20: begin dec_aluc = 4'b0010; dec_ovf_class = 1'b1; end
                6'h21: dec_aluc = 4'b0000;
                6'h22: begin dec_aluc = 4'b0011; dec_ovf_class = 1'b1; end
                6'h23: dec_aluc = 4'b0001;
                6'h24: dec_aluc = 4'b0100;
                6'h25: dec_aluc = 4'b0101;
                6'h26: dec_aluc = 4'b0110;
                6'h27: dec_aluc = 4'b0111;
                6'h2A: dec_aluc = 4'b1011;
                6'h2B: dec_aluc = 4'b1010;
                6'h00: begin dec_aluc = 4'b1110; dec_a = {27'b0, in_shamt}; end
                6'h02: begin dec_aluc = 4'b1101; dec_a = {27'b0, in_shamt}; end
                6'h03: begin dec_aluc = 4'b1100; dec_a = {27'b0, in_shamt}; end
                6'h04: begin dec_aluc = 4'b1110; dec_a = {27'b0, in_rs_val[4:0]}; end
                6'h06: begin dec_aluc = 4'b1101; dec_a = {27'b0, in_rs_val[4:0]}; end
                6'h07: begin dec_aluc = 4'b1100; dec_a = {27'b0, in_rs_val[4:0]}; end
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            case (in_opcode)
                6'h08: begin dec_aluc = 4'b0010; dec_b = imm_sext; dec_ovf_class = 1'b1; end
                6'h09: begin dec_aluc = 4'b0000; dec_b = imm_sext; end
                6'h0A: begin dec_aluc = 4'b1011; dec_b = imm_sext; end
                6'h0B: begin dec_aluc = 4'b1010; dec_b = imm_sext; end
                6'h0C: begin dec_aluc = 4'b0100; dec_b = imm_zext; end
                6'h0D: begin dec_aluc = 4'b0101; dec_b = imm_zext; end
                6'h0E: begin dec_aluc = 4'b0110; dec_b = imm_zext; end
                6'h0F: begin dec_aluc = 4'b1000; dec_b = imm_zext; dec_a = 32'b0; end
                default: dec_illegal = 1'b1;
            endcase
        end
        if (dec_illegal) begin
            dec_a         = 32'b0;
            dec_b         = 32'b0;
            dec_aluc      = 4'b0000;
            dec_ovf_class = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            alu_a         <= 32'b0;
            alu_b         <= 32'b0;
            alu_aluc      <= 4'b0;
            lat_dest      <= 5'b0;
            lat_ovf_class <= 1'b0;
            lat_illegal   <= 1'b0;
            out_valid     <= 1'b0;
            out_result    <= 32'b0;
            out_dest      <= 5'b0;
            out_wen       <= 1'b0;
            out_zero      <= 1'b0;
            out_carry     <= 1'b0;
            out_negative  <= 1'b0;
            out_ovf       <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            // accept can only be true in IDLE or in HOLD with out_ready, handled here once.
            if (accept) begin
                alu_a         <= dec_a;
                alu_b         <= dec_b;
                alu_aluc      <= dec_aluc;
                lat_dest      <= dec_dest;
                lat_ovf_class <= dec_ovf_class;
                lat_illegal   <= dec_illegal;
            end
            case (state)
                IDLE: if (accept) state <= EXEC;
                EXEC: state <= CAPT;
                CAPT: begin
                    state        <= HOLD;
                    out_valid    <= 1'b1;
                    out_result   <= lat_illegal ? 32'b0 : alu_r;
                    out_dest     <= lat_dest;
                    out_wen      <= !lat_illegal && !(TRAP_ON_OVF && cap_ovf) && (lat_dest != 5'b0);
                    out_zero     <= alu_zero;
                    out_carry    <= alu_carry;
                    out_negative <= alu_negative;
                    out_ovf      <= cap_ovf;
                    out_illegal  <= lat_illegal;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= accept ? EXEC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
